// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq
// Purpose : Sequences one 8-bit operation through a nibble-serial ALU.
//           States: IDLE -> LDA -> LO -> HI -> DONE.
// Revision: 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter bit BACK2BACK = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_cin,
    output logic [7:0] alu_op,
    output logic       alu_la,
    output logic       alu_lb,
    output logic       alu_oe,
    output logic       alu_r,
    output logic       alu_s,
    output logic       alu_v,
    output logic       alu_ne,
    output logic       alu_ci,
    output logic       alu_l,
    output logic       alu_h,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_res,
    output logic       rsp_z,
    output logic       rsp_n,
    output logic       rsp_h,
    output logic       rsp_c
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDA  = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [2:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_cin;
    logic       r_hc;
    logic [7:0] r_res;
    logic       r_carry;
    logic       r_zero;
    logic       w_accept;
    logic       w_arith;
    logic       w_sub;
    logic [3:0] w_fn;
    logic       w_ci_lo;

    assign req_ready = (r_state == S_IDLE) ||
                       (BACK2BACK && (r_state == S_DONE) && rsp_ready);
    assign w_accept  = req_valid && req_ready;
    assign w_sub     = (r_op == OP_SUB) || (r_op == OP_SBC) || (r_op == OP_CP);
    assign w_arith   = !r_op[2] || (r_op == OP_CP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_LDA;
            S_LDA:   w_next = S_LO;
            S_LO:    w_next = S_HI;
            S_HI:    w_next = S_DONE;
            S_DONE:  if (rsp_ready) w_next = w_accept ? S_LDA : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request fields are frozen at acceptance; hc comes from the low-nibble pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= 3'd0;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_cin   <= 1'b0;
            r_hc    <= 1'b0;
            r_res   <= 8'h00;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= req_op;
                r_a   <= req_a;
                r_b   <= req_b;
                r_cin <= req_cin;
            end
            if (r_state == S_LO) begin
                r_hc <= alu_carry;
            end
            if (r_state == S_HI) begin
                r_res   <= alu_result;
                r_carry <= alu_carry;
                r_zero  <= alu_zero;
            end
        end
    end

    always_comb begin
        w_fn    = 4'b0000;
        w_ci_lo = 1'b0;
        case (r_op)
            OP_ADD:  w_fn = 4'b0000;
            OP_ADC:  w_ci_lo = r_cin;
            OP_SUB:  begin w_fn = 4'b0001; w_ci_lo = 1'b1;   end
            OP_SBC:  begin w_fn = 4'b0001; w_ci_lo = !r_cin; end
            OP_AND:  w_fn = 4'b1000;
            OP_XOR:  w_fn = 4'b0100;
            OP_OR:   w_fn = 4'b1110;
            OP_CP:   begin w_fn = 4'b0001; w_ci_lo = 1'b1;   end
            default: w_fn = 4'b0000;
        endcase
    end

    always_comb begin
        alu_op    = 8'h00;
        alu_la    = 1'b0;
        alu_lb    = 1'b0;
        alu_oe    = 1'b0;
        {alu_r, alu_s, alu_v, alu_ne} = 4'b0000;
        alu_ci    = 1'b0;
        alu_l     = 1'b0;
        alu_h     = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_LDA: begin
                alu_op = r_a;
                alu_la = 1'b1;
            end
            S_LO: begin
                alu_op = r_b;
                alu_lb = 1'b1;
                alu_l  = 1'b1;
                {alu_r, alu_s, alu_v, alu_ne} = w_fn;
                alu_ci = w_ci_lo;
            end
            S_HI: begin
                alu_h  = 1'b1;
                alu_oe = 1'b1;
                {alu_r, alu_s, alu_v, alu_ne} = w_fn;
                alu_ci = w_arith && r_hc;
            end
            S_DONE:  rsp_valid = 1'b1;
            default: rsp_valid = 1'b0;
        endcase
    end

    // Subtract-class flags report borrow, i.e. the inverted ALU carries.
    assign rsp_res = (r_op == OP_CP) ? r_a : r_res;
    assign rsp_z   = r_zero;
    assign rsp_n   = w_sub;
    assign rsp_h   = (r_op == OP_AND) ? 1'b1 :
                     w_arith ? (w_sub ? !r_hc : r_hc) : 1'b0;
    assign rsp_c   = w_arith ? (w_sub ? !r_carry : r_carry) : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_seq
// Purpose : Scoreboard bench for alu_seq with a nibble-serial ALU model;
//           instance 0 has BACK2BACK=0, instance 1 has BACK2BACK=1.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    localparam logic [17:0] MASK_LDA = 18'h3FF87;
    localparam logic [17:0] MASK_HI  = 18'h003FF;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid [2];
    logic       req_ready [2];
    logic [2:0] req_op    [2];
    logic [7:0] req_a     [2];
    logic [7:0] req_b     [2];
    logic       req_cin   [2];
    logic [7:0] alu_op    [2];
    logic       alu_la    [2];
    logic       alu_lb    [2];
    logic       alu_oe    [2];
    logic       alu_r     [2];
    logic       alu_s     [2];
    logic       alu_v     [2];
    logic       alu_ne    [2];
    logic       alu_ci    [2];
    logic       alu_l     [2];
    logic       alu_h     [2];
    logic [7:0] alu_result[2];
    logic       alu_carry [2];
    logic       alu_zero  [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_res   [2];
    logic       rsp_z     [2];
    logic       rsp_n     [2];
    logic       rsp_h     [2];
    logic       rsp_c     [2];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_sent0 = 0;
    int          n_rsp [2];
    int          last_cyc [2];
    int          cyc = 0;
    bit          b2b_on = 1'b0;
    logic [11:0] q0 [$];
    logic [11:0] q1 [$];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] nib(input logic [3:0] x, input logic [3:0] y,
                                       input logic ci, input logic [3:0] fn);
        case (fn)
            4'b0000: nib = {1'b0, x} + {1'b0, y} + {4'b0, ci};
            4'b0001: nib = {1'b0, x} + {1'b0, ~y} + {4'b0, ci};
            4'b1000: nib = {1'b0, x & y};
            4'b0100: nib = {1'b0, x ^ y};
            4'b1110: nib = {1'b0, x | y};
            default: nib = 5'h00;
        endcase
    endfunction

    // Reference result {res, z, n, h, c} from whole-byte arithmetic.
    function automatic logic [11:0] exp_rsp(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
        int ai, bi, ci, r;
        logic [7:0] res;
        logic h, c, n;
        ai = a; bi = b; ci = 0; h = 1'b0; c = 1'b0; n = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                ci = (op == 3'd1 && cin) ? 1 : 0;
                r  = ai + bi + ci;
                h  = ((ai % 16) + (bi % 16) + ci) > 15;
                c  = r > 255;
            end
            3'd2, 3'd3, 3'd7: begin
                ci = (op == 3'd3 && cin) ? 1 : 0;
                r  = ai - bi - ci;
                h  = (ai % 16) < ((bi % 16) + ci);
                c  = ai < (bi + ci);
                n  = 1'b1;
            end
            3'd4:    begin r = ai & bi; h = 1'b1; end
            3'd5:    r = ai ^ bi;
            default: r = ai | bi;
        endcase
        res = r[7:0];
        return {(op == 3'd7) ? a : res, res == 8'h00, n, h, c};
    endfunction

    function automatic logic [3:0] exp_fn(input logic [2:0] op);
        case (op)
            3'd2, 3'd3, 3'd7: exp_fn = 4'b0001;
            3'd4:             exp_fn = 4'b1000;
            3'd5:             exp_fn = 4'b0100;
            3'd6:             exp_fn = 4'b1110;
            default:          exp_fn = 4'b0000;
        endcase
    endfunction

    function automatic logic exp_ci_lo(input logic [2:0] op, input logic cin);
        case (op)
            3'd1:             exp_ci_lo = cin;
            3'd2, 3'd7:       exp_ci_lo = 1'b1;
            3'd3:             exp_ci_lo = !cin;
            default:          exp_ci_lo = 1'b0;
        endcase
    endfunction

    function automatic logic [17:0] alu_vec(input int i);
        return {alu_op[i], alu_la[i], alu_lb[i], alu_oe[i], alu_r[i], alu_s[i],
                alu_v[i], alu_ne[i], alu_ci[i], alu_l[i], alu_h[i]};
    endfunction

    function automatic logic [11:0] rsp_vec(input int i);
        return {rsp_res[i], rsp_z[i], rsp_n[i], rsp_h[i], rsp_c[i]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] m_a;
        logic [7:0] m_b;
        logic [3:0] m_lo;
        logic [3:0] fn;
        logic [4:0] lo_n;
        logic [4:0] hi_n;

        alu_seq #(.BACK2BACK(g == 1)) u_dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_op(req_op[g]),
            .req_a(req_a[g]), .req_b(req_b[g]), .req_cin(req_cin[g]),
            .alu_op(alu_op[g]), .alu_la(alu_la[g]), .alu_lb(alu_lb[g]), .alu_oe(alu_oe[g]),
            .alu_r(alu_r[g]), .alu_s(alu_s[g]), .alu_v(alu_v[g]), .alu_ne(alu_ne[g]),
            .alu_ci(alu_ci[g]), .alu_l(alu_l[g]), .alu_h(alu_h[g]),
            .alu_result(alu_result[g]), .alu_carry(alu_carry[g]), .alu_zero(alu_zero[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_res(rsp_res[g]),
            .rsp_z(rsp_z[g]), .rsp_n(rsp_n[g]), .rsp_h(rsp_h[g]), .rsp_c(rsp_c[g])
        );

        // Nibble ALU: B flows through while its latch strobe is high.
        assign fn            = {alu_r[g], alu_s[g], alu_v[g], alu_ne[g]};
        assign lo_n          = nib(m_a[3:0], alu_op[g][3:0], alu_ci[g], fn);
        assign hi_n          = nib(m_a[7:4], m_b[7:4], alu_ci[g], fn);
        assign alu_result[g] = alu_h[g] ? {hi_n[3:0], m_lo} : 8'h00;
        assign alu_carry[g]  = alu_h[g] ? hi_n[4] : lo_n[4];
        assign alu_zero[g]   = alu_h[g] && ({hi_n[3:0], m_lo} == 8'h00);

        always @(posedge clk) begin
            if (alu_la[g]) m_a <= alu_op[g];
            if (alu_lb[g]) m_b <= alu_op[g];
            if (alu_l[g])  m_lo <= lo_n[3:0];
        end
    end

    always @(negedge clk) begin
        logic [11:0] e;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                if (i == 0) q0.push_back(exp_rsp(req_op[i], req_a[i], req_b[i], req_cin[i]));
                else        q1.push_back(exp_rsp(req_op[i], req_a[i], req_b[i], req_cin[i]));
            end
            if (rsp_valid[i] && rsp_ready[i]) begin
                check("sb_nonempty", ((i == 0) ? q0.size() : q1.size()) > 0, 1);
                e = 12'h000;
                if (i == 0 && q0.size() > 0) e = q0.pop_front();
                if (i == 1 && q1.size() > 0) e = q1.pop_front();
                check("rsp_data", rsp_vec(i), e);
                if (i == 1 && b2b_on && n_rsp[1] > 0)
                    check("b2b_gap", cyc - last_cyc[1], 4);
                last_cyc[i] = cyc;
                n_rsp[i]++;
            end
        end
    end

    task automatic send0(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input int mode);
        logic [11:0] e;
        logic [3:0]  fn;
        logic        cil, cih;
        int          k;
        e   = exp_rsp(op, a, b, cin);
        fn  = exp_fn(op);
        cil = exp_ci_lo(op, cin);
        cih = (op == 3'd4 || op == 3'd5 || op == 3'd6) ? 1'b0 : (e[2] ? !e[1] : e[1]);
        @(posedge clk); #1;
        rsp_ready[0] = (mode != 1);
        req_valid[0] = 1'b1; req_op[0] = op; req_a[0] = a; req_b[0] = b; req_cin[0] = cin;
        k = 0;
        while (!req_ready[0] && k < 20) begin @(posedge clk); #1; k++; end
        check("accept_timeout", k < 20, 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0; req_op[0] = ~op; req_a[0] = ~a; req_b[0] = ~b; req_cin[0] = !cin;
        @(negedge clk); check("lda", alu_vec(0) & MASK_LDA, {a, 3'b100, 4'b0000, 3'b000});
        @(negedge clk); check("lo", alu_vec(0), {b, 3'b010, fn, cil, 2'b10});
        if (mode == 2) begin
            #1 reset = 1'b1;
            #1 check("rst_async_alu", alu_vec(0), 0);
            @(posedge clk); #1 reset = 1'b0;
            q0.delete();
            @(negedge clk);
            check("rst_alu", alu_vec(0), 0);
            check("rst_rsp_valid", rsp_valid[0], 0);
            check("rst_req_ready", req_ready[0], 1);
        end else begin
            @(negedge clk); check("hi", alu_vec(0) & MASK_HI, {8'h00, 3'b001, fn, cih, 2'b01});
            @(negedge clk); check("done_valid", rsp_valid[0], 1);
            n_sent0++;
            if (mode == 1) begin
                for (int j = 0; j < 5; j++) begin
                    check("hold_rsp", rsp_vec(0), e);
                    check("hold_req_ready", req_ready[0], 0);
                    check("hold_valid", rsp_valid[0], 1);
                    @(negedge clk);
                end
                @(posedge clk); #1 rsp_ready[0] = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("idle_req_ready", req_ready[0], 1);
                check("idle_rsp_valid", rsp_valid[0], 0);
            end else begin
                @(negedge clk); check("idle_after", rsp_valid[0], 0);
            end
        end
    endtask

    task automatic drive_rand1();
        req_op[1]  = 3'($urandom_range(0, 7));
        req_a[1]   = 8'($urandom);
        req_b[1]   = 8'($urandom);
        req_cin[1] = 1'($urandom);
    endtask

    initial begin
        int  sent, k;
        bit  acc;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; rsp_ready[i] = 1'b0; req_op[i] = 3'd0;
            req_a[i] = 8'h00; req_b[i] = 8'h00; req_cin[i] = 1'b0;
            n_rsp[i] = 0; last_cyc[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("in_rst_valid", rsp_valid[0], 0);
        check("in_rst_alu", alu_vec(0), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_rsp", rsp_vec(i), 0);
            check("rst_alu_def", alu_vec(i), 0);
            check("rst_valid", rsp_valid[i], 0);
            check("rst_ready", req_ready[i], 1);
        end

        send0(3'd6, 8'h5A, 8'h0F, 1'b0, 0);
        send0(3'd0, 8'h0F, 8'h01, 1'b0, 0);
        send0(3'd0, 8'hFF, 8'h01, 1'b0, 0);
        send0(3'd3, 8'h10, 8'h00, 1'b1, 0);
        send0(3'd7, 8'h3C, 8'h3C, 1'b0, 0);
        send0(3'd5, 8'hA5, 8'h3C, 1'b0, 1);
        send0(3'd2, 8'h40, 8'h13, 1'b0, 2);
        send0(3'd4, 8'hF0, 8'h3C, 1'b0, 0);
        send0(3'd1, 8'h8F, 8'h70, 1'b1, 0);
        send0(3'd3, 8'h00, 8'h00, 1'b1, 0);
        repeat (6) send0(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom), 0);

        b2b_on = 1'b1;
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        drive_rand1();
        req_valid[1] = 1'b1;
        sent = 0; k = 0;
        while (n_rsp[1] < 8 && k < 200) begin
            @(negedge clk); k++;
            acc = req_valid[1] && req_ready[1];
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 8) drive_rand1();
                else req_valid[1] = 1'b0;
            end
        end
        repeat (4) @(negedge clk);

        check("b2b_count", n_rsp[1], 8);
        check("seq_count", n_rsp[0], n_sent0);
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
